// File: rtl/fetch_pkg.sv
// fetch_pkg: constants, next-PC selector encoding and PC increment helper
// shared by the instruction-fetch stage. No ports.
// Imported by next_pc_mux and fetch_pc_unit.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Which source the PC register takes at the next edge.
   typedef enum logic [2:0] {
      SEL_SEQ,
      SEL_BRANCH,
      SEL_JUMP,
      SEL_JREG,
      SEL_HOLD
   } next_pc_sel_t;

   // Sequential successor; the 32-bit add wraps FFFF_FFFC to 0.
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/next_pc_mux.sv
// next_pc_mux: picks the next fetch address from hold / JR / J / branch / PC+4.
// Latency: purely combinational, no state.
// Backpressure: stall forces SEL_HOLD; redirects only count when IF/ID is valid.
// Ports: pc, stall, if_id_valid, if_id_pc_plus4 and the three redirect requests
// with their operands in; sel (chosen source) and next_pc (its address) out.
module next_pc_mux
   import fetch_pkg::*;
(
   input  logic [31:0]   pc,
   input  logic          stall,
   input  logic          if_id_valid,
   input  logic [31:0]   if_id_pc_plus4,
   input  logic          branch_taken,
   input  logic [31:0]   branch_offset,
   input  logic          jump,
   input  logic [27:0]   jump_target,
   input  logic          jump_reg,
   input  logic [29:0]   jump_reg_word,  // JumpRegAddr[31:2]; low bits are forced to 0
   output next_pc_sel_t  sel,
   output logic [31:0]   next_pc
);

   logic [31:0] branch_target;
   logic [31:0] jump_tgt_full;
   logic [31:0] jreg_target;

   assign branch_target = if_id_pc_plus4 + branch_offset;
   assign jump_tgt_full = {if_id_pc_plus4[31:28], jump_target};
   assign jreg_target   = {jump_reg_word, 2'b00};

   always_comb begin
      sel     = SEL_SEQ;
      next_pc = pc_plus4(pc);
      // Stall wins over redirects: the redirecting instruction stays in ID
      // and re-asserts its request once the stall clears.
      if (stall) begin
         sel     = SEL_HOLD;
         next_pc = pc;
      end else if (if_id_valid && jump_reg) begin
         sel     = SEL_JREG;
         next_pc = jreg_target;
      end else if (if_id_valid && jump) begin
         sel     = SEL_JUMP;
         next_pc = jump_tgt_full;
      end else if (if_id_valid && branch_taken) begin
         sel     = SEL_BRANCH;
         next_pc = branch_target;
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register, IF/ID pipeline register, fetch counter, JR alignment flag.
// Latency: instruction at PC in cycle N is on IfIdInstr in N+1; a redirect costs one bubble.
// Backpressure: Stall freezes PC, IF/ID and FetchCount; redirects are not queued.
// Ports: Clk/Reset (sync, active high), Stall, BranchTaken/BranchOffset, Jump/JumpTarget,
// JumpReg/JumpRegAddr, InstrIn in; PC, IfIdInstr, IfIdPcPlus4, IfIdValid,
// AddrMisaligned, FetchCount out.
module fetch_pc_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchOffset,
   input  logic        Jump,
   input  logic [27:0] JumpTarget,
   input  logic        JumpReg,
   input  logic [31:0] JumpRegAddr,
   input  logic [31:0] InstrIn,
   output logic [31:0] PC,
   output logic [31:0] IfIdInstr,
   output logic [31:0] IfIdPcPlus4,
   output logic        IfIdValid,
   output logic        AddrMisaligned,
   output logic [31:0] FetchCount
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic        misaligned_q, misaligned_d;
   logic [31:0] count_q, count_d;

   next_pc_sel_t sel;
   logic [31:0]  next_pc;

   next_pc_mux u_next_pc_mux (
      .pc             (pc_q),
      .stall          (Stall),
      .if_id_valid    (valid_q),
      .if_id_pc_plus4 (pc4_q),
      .branch_taken   (BranchTaken),
      .branch_offset  (BranchOffset),
      .jump           (Jump),
      .jump_target    (JumpTarget),
      .jump_reg       (JumpReg),
      .jump_reg_word  (JumpRegAddr[31:2]),
      .sel            (sel),
      .next_pc        (next_pc)
   );

   always_comb begin
      pc_d         = pc_q;
      instr_d      = instr_q;
      pc4_d        = pc4_q;
      valid_d      = valid_q;
      count_d      = count_q;
      misaligned_d = 1'b0;
      case (sel)
         SEL_HOLD: begin
            // everything frozen; the flag is a single-cycle pulse so it drops
         end
         SEL_SEQ: begin
            pc_d    = next_pc;
            instr_d = InstrIn;
            pc4_d   = pc_plus4(pc_q);
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
         end
         default: begin
            // Redirect: the instruction fetched this cycle is wrong-path.
            pc_d         = next_pc;
            instr_d      = NOP_INSTR;
            pc4_d        = 32'd0;
            valid_d      = 1'b0;
            misaligned_d = (sel == SEL_JREG) && (JumpRegAddr[1:0] != 2'b00);
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc_q         <= RESET_PC;
         instr_q      <= NOP_INSTR;
         pc4_q        <= 32'd0;
         valid_q      <= 1'b0;
         misaligned_q <= 1'b0;
         count_q      <= 32'd0;
      end else begin
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         pc4_q        <= pc4_d;
         valid_q      <= valid_d;
         misaligned_q <= misaligned_d;
         count_q      <= count_d;
      end
   end

   assign PC             = pc_q;
   assign IfIdInstr      = instr_q;
   assign IfIdPcPlus4    = pc4_q;
   assign IfIdValid      = valid_q;
   assign AddrMisaligned = misaligned_q;
   assign FetchCount     = count_q;

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage of the pipelined MIPS core: owns the program counter, drives the instruction-memory address, and captures fetched instructions into the IF/ID pipeline register. It consumes the 28-bit word-aligned jump field produced by the two-bit left shifter and concatenates it with the upper PC bits. It also resolves redirects from ID (branch, jump, jump-register), handles stalls, and flushes the wrong-path instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high.
- Stall  in  1  hazard hold; freezes PC, IF/ID and FetchCount.
- BranchTaken  in  1  ID-resolved taken branch.
- BranchOffset  in  32  sign-extended immediate, already shifted left by 2.
- Jump  in  1  J/JAL in ID.
- JumpTarget  in  28  shifted 26-bit jump field.
- JumpReg  in  1  JR/JALR in ID.
- JumpRegAddr  in  32  register-sourced target.
- InstrIn  in  32  combinational instruction-memory read data at PC.
- PC  out  32  current fetch address.
- IfIdInstr  out  32  latched instruction.
- IfIdPcPlus4  out  32  PC+4 of the latched instruction.
- IfIdValid  out  1  IF/ID holds a real instruction.
- AddrMisaligned  out  1  one-cycle pulse when a JumpRegAddr with bits [1:0] ≠ 0 is accepted.
- FetchCount  out  32  count of instructions latched valid into IF/ID.

## Operation
- Reset values: PC = RESET_PC. IfIdInstr = 32'h0000_0000 (NOP). IfIdPcPlus4 = 0. IfIdValid = 0. AddrMisaligned = 0. FetchCount = 0.
- Next-PC priority at each edge: Reset > Stall > JumpReg > Jump > BranchTaken > PC+4.
- Stall outranks redirects, because the redirecting instruction is itself held in ID and re-presents the redirect after the stall.
- Redirect targets:
  - JumpReg: {JumpRegAddr[31:2], 2'b00}.
  - Jump: {IfIdPcPlus4[31:28], JumpTarget}.
  - Branch: IfIdPcPlus4 + BranchOffset, modulo 2^32.
- Sequential: PC + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- On an accepted redirect: IF/ID loads a bubble (Instr = NOP, PcPlus4 = 0, Valid = 0). FetchCount does not increment.
- Otherwise, when not stalled: IF/ID loads {InstrIn, PC+4, 1}, and FetchCount increments, wrapping at 2^32.
- Multiple redirect inputs asserted together: highest priority wins; the others are ignored, not queued.
- Redirect inputs are qualified only by IfIdValid. With IfIdValid = 0 they are ignored, so a bubble in ID cannot redirect.
- AddrMisaligned is high for the cycle after the edge that accepted a misaligned JumpReg, and 0 otherwise.

## Timing
- PC is registered; instruction memory is read combinationally in the same cycle.
- Fetch latency: the instruction at PC in cycle N appears on IfIdInstr in cycle N+1.
- Redirect asserted in cycle N:
  - Cycle N+1: PC = target, IfIdValid = 0.
  - Cycle N+2: IF/ID holds the target instruction with IfIdValid = 1.
  - Cost: exactly one bubble.
- Stall for k cycles: PC, IF/ID and FetchCount stay constant for k edges; normal flow resumes on the first unstalled edge.
- Reset mid-operation overrides Stall and all redirects in the same cycle. First valid IF/ID appears one edge after Reset deasserts.
- Outputs change only on Clk rising edges.

## Structure
- Shared package (fetch_pkg):
  - NOP_INSTR = 32'h0000_0000.
  - Default RESET_PC.
  - Enum next_pc_sel_t {SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_JREG, SEL_HOLD}.
- Sub-module next_pc_mux: combinational. Computes the three targets, applies priority, and outputs next_pc_sel_t plus the next PC value.
- The top level holds the PC register, the IF/ID register, the FetchCount counter and the AddrMisaligned flop.

## Test plan
- Reset, then free run with mem[i] = i:
  - PC sequence 0, 4, 8, 12.
  - Cycle 1: IfIdInstr = mem[0], IfIdPcPlus4 = 4, IfIdValid = 1.
  - FetchCount = 3 after 3 edges.
- Jump, low region: IfIdPcPlus4 = 32'h0000_0010, JumpTarget = 28'h000_0100 → next PC = 32'h0000_0100, IfIdValid = 0 for one cycle.
- Jump, upper bits kept: IfIdPcPlus4 = 32'h1000_0008, JumpTarget = 28'h000_0040 → PC = 32'h1000_0040.
- Branch backward: IfIdPcPlus4 = 32'h0000_0020, BranchOffset = 32'hFFFF_FFF0 → PC = 32'h0000_0010.
- Branch and Jump together: Jump wins.
- Stall: Stall = 1 for 2 cycles at PC = 32'h8 → PC, IF/ID and FetchCount unchanged.
- Stall with BranchTaken also asserted: branch is not taken until Stall drops.
- Misaligned JR and wrap-around:
  - JumpRegAddr = 32'h0000_0043 → PC = 32'h0000_0040, AddrMisaligned = 1 for exactly one cycle.
  - PC = 32'hFFFF_FFFC, sequential → PC = 0.
- Reset mid-run with Jump and Stall asserted → next cycle PC = RESET_PC, IfIdValid = 0, FetchCount = 0, AddrMisaligned = 0.
